// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int unsigned MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection for the arbiter: data beats fetch unless fetch has lost
// MAX_WAIT contested grants in a row.
import mem_arb_pkg::*;

module mem_arb_prio #(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant,
    output logic winner
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] r_starve_cnt;
    logic       w_force_if;

    assign w_force_if = if_req && (r_starve_cnt >= MAX_CNT);
    assign winner     = (d_req && !w_force_if) ? OWN_D : OWN_IF;

    // Only contested data grants count against fetch; any fetch grant clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                r_starve_cnt <= '0;
            end else if (if_req && (r_starve_cnt < MAX_CNT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one wait-state
// memory port; requests are latched at grant so mem_* stays stable.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  w_grant;
    logic                  w_winner;

    assign w_grant = (r_state == ST_IDLE) && (if_req || d_req);

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (w_grant),
        .winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (if_req || d_req) w_next = ST_BUSY;
            ST_BUSY: if (mem_ready)       w_next = ST_RESP;
            ST_RESP:                      w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        busy    = 1'b0;
        if_ack  = 1'b0;
        d_ack   = 1'b0;
        case (r_state)
            ST_BUSY: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            ST_RESP: begin
                busy    = 1'b1;
                if_ack  = (r_owner == OWN_IF);
                d_ack   = (r_owner == OWN_D);
            end
            default: ;
        endcase
    end

    // Fetch grants latch a read with all write controls forced low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_winner;
                if (w_winner == OWN_D) begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wstrb <= d_wstrb;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr  <= if_addr;
                    r_we    <= 1'b0;
                    r_wstrb <= '0;
                    r_wdata <= '0;
                end
            end
            if ((r_state == ST_BUSY) && mem_ready) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_wstrb = r_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_rdata;
    assign d_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-port request queues, a wait-state memory
// model and an in-order scoreboard of expected memory accesses.
module tb_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int mem_wait = 0;
    int wcnt = 0;
    int acc_cyc = 0;

    logic [31:0] if_pend[$];
    req_t        d_pend[$];
    req_t        sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    function automatic req_t mk(input logic is_d, input logic [31:0] addr,
                                input logic we, input logic [3:0] wstrb,
                                input logic [31:0] wdata);
        req_t r;
        r.is_d = is_d; r.addr = addr; r.we = we; r.wstrb = wstrb; r.wdata = wdata;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_if(input logic [31:0] a);
        if_pend.push_back(a);
        sb.push_back(mk(1'b0, a, 1'b0, 4'h0, 32'h0));
    endtask

    task automatic req_d(input logic [31:0] a, input logic we, input logic [3:0] ws,
                         input logic [31:0] wd);
        d_pend.push_back(mk(1'b1, a, we, ws, wd));
    endtask

    // Advance one cycle; requesters retire on ack and present their next request.
    task automatic tick();
        @(negedge clk);
        if (if_ack && if_pend.size() > 0) void'(if_pend.pop_front());
        if (d_ack && d_pend.size() > 0) void'(d_pend.pop_front());
        if (if_pend.size() > 0) begin
            if_req = 1'b1; if_addr = if_pend[0];
        end else begin
            if_req = 1'b0;
        end
        if (d_pend.size() > 0) begin
            d_req = 1'b1; d_addr = d_pend[0].addr; d_we = d_pend[0].we;
            d_wstrb = d_pend[0].wstrb; d_wdata = d_pend[0].wdata;
        end else begin
            d_req = 1'b0;
        end
    endtask

    task automatic run_all(input int max_cyc);
        int n = 0;
        while ((if_pend.size() + d_pend.size() + sb.size()) > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain", if_pend.size() + d_pend.size() + sb.size(), 0);
    endtask

    // Memory model: mem_ready after mem_wait low cycles; junk data otherwise.
    always @(negedge clk) begin
        if (mem_req && !reset) begin
            if (wcnt == mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
            wcnt++;
        end else begin
            wcnt = 0;
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // Scoreboard monitor: every mem_req cycle and every ack against the head entry.
    always @(negedge clk) begin
        if (reset) begin
            acc_cyc = 0;
        end else begin
            if (mem_req) begin
                acc_cyc++;
                if (sb.size() == 0) begin
                    chk("mem_req_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, sb[0].wstrb});
                    if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (if_ack || d_ack) begin
                chk("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("ack_owner", {31'd0, d_ack}, {31'd0, sb[0].is_d});
                    chk("ack_rdata", d_ack ? d_rdata : if_rdata, mem_val(sb[0].addr));
                    chk("ack_latency", acc_cyc, mem_wait + 1);
                    void'(sb.pop_front());
                end
                acc_cyc = 0;
            end
        end
    end

    initial begin
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_ctl", {27'd0, mem_we, mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        reset = 1'b0;

        // Single fetch, minimum latency
        mem_wait = 0;
        req_if(32'h10);
        tick();
        tick();
        chk("f_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("f_if_ack", {31'd0, if_ack}, 32'd1);
        chk("f_if_rdata", if_rdata, 32'h0050_0093);
        chk("f_d_ack", {31'd0, d_ack}, 32'd0);
        tick();
        chk("f_busy", {31'd0, busy}, 32'd0);
        run_all(50);

        // Contention: data wins first, then fetch
        req_d(32'h100, 1'b0, 4'h0, 32'h0);
        sb.push_back(mk(1'b1, 32'h100, 1'b0, 4'h0, 32'h0));
        req_if(32'h20);
        run_all(50);

        // Starvation: four contested data grants, then fetch is forced through
        for (int i = 0; i < 5; i++) req_d(32'h400 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 32'h400 + 32'(i * 4), 1'b0, 4'h0, 32'h0));
        req_if(32'h30);
        sb.push_back(mk(1'b1, 32'h410, 1'b0, 4'h0, 32'h0));
        run_all(100);

        // Counter cleared by the forced fetch: data wins the next contest
        req_d(32'h500, 1'b0, 4'h0, 32'h0);
        sb.push_back(mk(1'b1, 32'h500, 1'b0, 4'h0, 32'h0));
        req_if(32'h40);
        run_all(50);

        // Store with three wait states
        mem_wait = 3;
        req_d(32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        sb.push_back(mk(1'b1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF));
        run_all(50);

        // Back-to-back data requests: new address accepted right after RESP
        mem_wait = 0;
        req_d(32'h200, 1'b1, 4'b1111, 32'h1234_5678);
        req_d(32'h204, 1'b0, 4'h0, 32'h0);
        sb.push_back(mk(1'b1, 32'h200, 1'b1, 4'b1111, 32'h1234_5678));
        sb.push_back(mk(1'b1, 32'h204, 1'b0, 4'h0, 32'h0));
        tick(); tick(); tick();
        chk("b2b_d_ack", {31'd0, d_ack}, 32'd1);
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("b2b_mem_req", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr", mem_addr, 32'h204);
        run_all(50);

        // Reset during a stalled access; the held request is re-issued
        mem_wait = 10;
        req_d(32'h300, 1'b0, 4'h0, 32'h0);
        sb.push_back(mk(1'b1, 32'h300, 1'b0, 4'h0, 32'h0));
        tick(); tick(); tick();
        chk("rb_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rb_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rb_busy", {31'd0, busy}, 32'd0);
        chk("rb_acks", {30'd0, if_ack, d_ack}, 32'd0);
        tick();
        mem_wait = 1;
        reset = 1'b0;
        run_all(50);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
